// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter with a registered one-hot grant built from three 2:4 predecoders.
// Optional macro ARB_TIMEOUT_EN ends a tenure after MAX_HOLD grant cycles.
module rr_decode_arbiter #(
  parameter int unsigned N        = 64,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  if (N < 2 || N > 64) begin : g_bad_n
    $error("rr_decode_arbiter: N must be in 2..64");
  end
  if (IDX_W != 6) begin : g_bad_idx_w
    $error("rr_decode_arbiter: IDX_W must be 6");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_decode_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [3:0]       pre0, pre1, pre2;
  logic [N-1:0]     win_dec;
  logic             tenure_end;

  function automatic logic [3:0] dec2to4(input logic [1:0] sel);
    logic [3:0] onehot;
    unique case (sel)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Circular scan starting at ptr; wrap is at N, so indices >= N are never visited.
  always_comb begin : p_arb
    logic [IDX_W:0] pos;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) begin
        pos = pos - (IDX_W+1)'(N);
      end
      if (!win_found && req[pos[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    pre0 = dec2to4(win_idx[1:0]);
    pre1 = dec2to4(win_idx[3:2]);
    pre2 = dec2to4(win_idx[5:4]);
  end

  for (genvar i = 0; i < N; i++) begin : g_dec
    assign win_dec[i] = pre2[i / 16] & pre1[(i / 4) % 4] & pre0[i % 4];
  end

`ifdef ARB_TIMEOUT_EN
  assign tenure_end = !req[gnt_idx_q] || (hold_cnt_q == 8'(MAX_HOLD));
`else
  assign tenure_end = !req[gnt_idx_q];
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      StIdle, StGap: begin
        if (win_found) begin
          state_d     = StGrant;
          gnt_idx_d   = win_idx;
          gnt_d       = win_dec;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd1;
        end else begin
          state_d     = StIdle;
          gnt_idx_d   = '0;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end
      end
      StGrant: begin
        if (tenure_end) begin
          // GAP gives one turnaround cycle and re-arbitrates from the next index.
          state_d     = StGap;
          gnt_idx_d   = '0;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          ptr_d       = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
        end else if (hold_cnt_q != 8'hff) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = StIdle;
        gnt_idx_d   = '0;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: rounds of requests, expected grant order
// computed from the round-robin rule, checked by an independent monitor.
module tb_rr_decode_arbiter;
  localparam int unsigned N        = 64;
  localparam int unsigned N40      = 40;
  localparam int unsigned MAX_HOLD = 15;
`ifdef ARB_TIMEOUT_EN
  localparam int LongLen = MAX_HOLD;
`else
  localparam int LongLen = 40;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [5:0]     gnt_idx;
  logic           gnt_valid;
  logic [N40-1:0] req40 = '0;
  logic [N40-1:0] gnt40;
  logic [5:0]     gnt40_idx;
  logic           gnt40_valid;

  always #5 clk = ~clk;

  rr_decode_arbiter #(.N(N), .IDX_W(6), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  rr_decode_arbiter #(.N(N40), .IDX_W(6), .MAX_HOLD(MAX_HOLD)) dut40 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req40),
    .gnt       (gnt40),
    .gnt_idx   (gnt40_idx),
    .gnt_valid (gnt40_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed { int idx; int len; } exp_t;
  exp_t exp_q[$];

  // Monitor: one pop per tenure start
  bit   mon_en = 1'b0;
  int   round_id = 0;
  int   seen_round = -1;
  logic prev_valid = 1'b0;
  int   idle_cnt = 0;
  int   cur_len = 0;
  int   cur_idx = 0;
  int   cur_exp_len = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt_valid) begin
        check("gnt_onehot", gnt, 64'd1 << gnt_idx);
      end else begin
        check("gnt_idle", gnt, 64'd0);
        check("idx_idle", 64'(gnt_idx), 64'd0);
      end
      if (gnt_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: got idx %0d, required no grant", gnt_idx);
          cur_exp_len = -1;
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_idx", 64'(gnt_idx), 64'(mon_e.idx));
          cur_exp_len = mon_e.len;
        end
        if (seen_round != round_id) seen_round = round_id;
        else check("gap_cycles", 64'(idle_cnt), 64'd1);
        cur_idx = int'(gnt_idx);
        cur_len = 1;
      end else if (gnt_valid && prev_valid) begin
        check("idx_stable", 64'(gnt_idx), 64'(cur_idx));
        cur_len++;
      end else if (!gnt_valid && prev_valid) begin
        check("tenure_len", 64'(cur_len), 64'(cur_exp_len));
        idle_cnt = 1;
      end else begin
        idle_cnt++;
      end
    end else begin
      idle_cnt = 0;
    end
    prev_valid = gnt_valid;
  end

  // Requester agents and reference model
  int   len_a[64];
  int   rem_a[64];
  int   held_a[64];
  bit   drop_a[64];
  int   m_ptr = 0;
  logic [63:0] rnd_mask;

  task automatic clear_reqs();
    for (int i = 0; i < 64; i++) begin
      len_a[i] = 0;
      rem_a[i] = 0;
    end
  endtask

  task automatic set_req(input int i, input int len, input int reps);
    len_a[i] = len;
    rem_a[i] = reps;
  endtask

  task automatic run_round(input logic [63:0] mask);
    int  cnt[64];
    int  total;
    int  w;
    int  budget;
    bit  busy;
    total = 0;
    for (int i = 0; i < 64; i++) begin
      cnt[i]    = mask[i] ? rem_a[i] : 0;
      total    += cnt[i];
      held_a[i] = 0;
      drop_a[i] = 1'b0;
    end
    // Each served requester re-raises before arbitration, so the order is a circular walk.
    for (int t = 0; t < total; t++) begin
      w = -1;
      for (int k = 0; k < int'(N) && w < 0; k++) begin
        if (cnt[(m_ptr + k) % N] > 0) w = (m_ptr + k) % N;
      end
      exp_q.push_back('{idx: w, len: len_a[w]});
      cnt[w]--;
      m_ptr = (w + 1) % N;
    end
    round_id++;
    @(posedge clk);
    #1;
    req = mask;
    budget = 0;
    busy = 1'b1;
    while (busy && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
      for (int i = 0; i < 64; i++) begin
        if (drop_a[i]) begin
          drop_a[i] = 1'b0;
          if (rem_a[i] > 0) req[i] = 1'b1;
        end else if (req[i] && gnt_valid && int'(gnt_idx) == i) begin
          held_a[i]++;
          if (held_a[i] == len_a[i]) begin
            req[i]    = 1'b0;
            held_a[i] = 0;
            rem_a[i]--;
            drop_a[i] = 1'b1;
          end
        end
      end
      busy = gnt_valid;
      for (int i = 0; i < 64; i++) if (rem_a[i] != 0 || drop_a[i]) busy = 1'b1;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL round_timeout: round %0d still busy after %0d cycles, required done",
               round_id, budget);
      req = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("round_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_n40();
    int exp40[6];
    int waited;
    exp40 = '{0, 20, 39, 0, 20, 39};
    @(posedge clk);
    #1;
    req40 = '0;
    req40[0]  = 1'b1;
    req40[20] = 1'b1;
    req40[39] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      while (!gnt40_valid && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
      end
      if (!gnt40_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL n40_wait: no grant for step %0d, required idx %0d", k, exp40[k]);
        break;
      end
      check("n40_idx", 64'(gnt40_idx), 64'(exp40[k]));
      check("n40_gnt", 64'(gnt40), 64'd1 << exp40[k]);
      req40[exp40[k]] = 1'b0;
      @(posedge clk);
      #1;
      check("n40_gap", 64'(gnt40_valid), 64'd0);
      if (k < 3) req40[exp40[k]] = 1'b1;
    end
    req40 = '0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    #1;
    check("rst_gnt", gnt, 64'd0);
    check("rst_idx", 64'(gnt_idx), 64'd0);
    check("rst_valid", 64'(gnt_valid), 64'd0);
    check("rst_gnt40", 64'(gnt40), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    clear_reqs();
    set_req(37, 4, 1);
    run_round(64'd1 << 37);

    clear_reqs();
    set_req(3, 2, 2);
    set_req(10, 2, 2);
    set_req(63, 2, 2);
    run_round((64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63));

    clear_reqs();
    set_req(62, 1, 1);
    run_round(64'd1 << 62);
    clear_reqs();
    set_req(63, 2, 1);
    set_req(0, 2, 1);
    run_round((64'd1 << 63) | 64'd1);

    clear_reqs();
    set_req(7, LongLen, 1);
    set_req(8, 2, 1);
    run_round((64'd1 << 7) | (64'd1 << 8));

    clear_reqs();
    for (int i = 0; i < 64; i++) set_req(i, 1, 1);
    run_round('1);

    for (int r = 0; r < 30; r++) begin
      rnd_mask = {$urandom(), $urandom()};
      if (r % 3 == 0) rnd_mask &= {$urandom(), $urandom()};
      if (r % 3 == 1) rnd_mask &= {$urandom(), $urandom()} & {$urandom(), $urandom()};
      if (rnd_mask == 0) rnd_mask[$urandom_range(63, 0)] = 1'b1;
      clear_reqs();
      for (int i = 0; i < 64; i++) begin
        if (rnd_mask[i]) set_req(i, int'($urandom_range(4, 1)), int'($urandom_range(2, 1)));
      end
      run_round(rnd_mask);
    end

    run_n40();

    // Asynchronous reset in the middle of a grant to idx 5
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    req = 64'd1 << 5;
    waited = 0;
    while (!gnt_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("pre_rst_idx", 64'(gnt_idx), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 64'd0);
    check("async_rst_valid", 64'(gnt_valid), 64'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", 64'(gnt_valid), 64'd0);
    end
    mon_en = 1'b1;

    clear_reqs();
    set_req(5, 3, 1);
    set_req(2, 1, 2);
    run_round((64'd1 << 5) | (64'd1 << 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
